tt_alu_accum: RTL

Parametrised, clocked arithmetic unit for the TinyTapeout user tile. It extends the plain combinational adder that drives the tile outputs with the following:
- registered results and a valid handshake;
- a persistent accumulator;
- saturating or wrapping arithmetic;
- an iterative shift-add multiplier with a busy indication.

It sits between the dedicated input pins and `uo_out`. The tile top maps `a`/`b`/control onto `ui_in`/`uio_in`.

---
 rtl/tt_alu_accum.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/tt_alu_accum.sv
// Clocked ALU for the TinyTapeout user tile: registered results with valid pulse,
// persistent accumulator, saturating/wrapping arithmetic and an iterative multiplier.
module tt_alu_accum #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             sat,
   input  logic             in_valid,
   input  logic             clear,
   output logic [WIDTH-1:0] y,
   output logic             flag,
   output logic             out_valid,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_ACC   = 3'b010,
      OP_DEC   = 3'b011,
      OP_MUL   = 3'b100,
      OP_RDHI  = 3'b101,
      OP_RDACC = 3'b110,
      OP_NOP   = 3'b111
   } op_t;

   typedef enum logic {
      ST_IDLE,
      ST_MUL
   } state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mcand;
   logic               sat_q;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   hi;
   logic               pend_v;
   logic [WIDTH-1:0]   pend_y;
   logic               pend_f;
   logic [WIDTH-1:0]   y_q;
   logic               flag_q;
   logic               ov_q;
   logic               busy_q;

   op_t                op_c;
   logic               accept;
   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     sub_s;
   logic [WIDTH:0]     acc_add;
   logic [WIDTH:0]     acc_sub;
   logic [WIDTH-1:0]   alu_y;
   logic               alu_f;
   logic               acc_we;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_nx;
   logic [WIDTH-1:0]   prod_hi;
   logic [WIDTH-1:0]   prod_lo;

   assign op_c   = op_t'(op);
   assign accept = ena && in_valid && !busy_q && !clear;

   always_comb begin
      add_s   = {1'b0, a} + {1'b0, b};
      sub_s   = {1'b0, a} - {1'b0, b};
      acc_add = {1'b0, acc} + {1'b0, a};
      acc_sub = {1'b0, acc} - {1'b0, a};
      alu_y   = '0;
      alu_f   = 1'b0;
      acc_we  = 1'b0;
      case (op_c)
         OP_ADD: begin
            alu_y = (sat && add_s[WIDTH]) ? '1 : add_s[WIDTH-1:0];
            alu_f = add_s[WIDTH];
         end
         OP_SUB: begin
            alu_y = (sat && sub_s[WIDTH]) ? '0 : sub_s[WIDTH-1:0];
            alu_f = sub_s[WIDTH];
         end
         OP_ACC: begin
            alu_y  = (sat && acc_add[WIDTH]) ? '1 : acc_add[WIDTH-1:0];
            alu_f  = acc_add[WIDTH];
            acc_we = 1'b1;
         end
         OP_DEC: begin
            alu_y  = (sat && acc_sub[WIDTH]) ? '0 : acc_sub[WIDTH-1:0];
            alu_f  = acc_sub[WIDTH];
            acc_we = 1'b1;
         end
         OP_RDHI:  alu_y = hi;
         OP_RDACC: alu_y = acc;
         default: begin
            alu_y  = '0;
            alu_f  = 1'b0;
            acc_we = 1'b0;
         end
      endcase
   end

   // Shift-add step: conditionally add the multiplicand into the upper half,
   // then shift the whole product right; the multiplier drains out of the low half.
   always_comb begin
      mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      prod_nx = {mul_sum, prod[WIDTH-1:1]};
      prod_hi = prod_nx[2*WIDTH-1:WIDTH];
      prod_lo = prod_nx[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         prod   <= '0;
         mcand  <= '0;
         sat_q  <= 1'b0;
         acc    <= '0;
         hi     <= '0;
         pend_v <= 1'b0;
         pend_y <= '0;
         pend_f <= 1'b0;
         y_q    <= '0;
         flag_q <= 1'b0;
         ov_q   <= 1'b0;
         busy_q <= 1'b0;
      end else if (!ena) begin
         ov_q <= 1'b0;
      end else begin
         // Single-cycle results pass through one staging register so they
         // appear one edge after accept; acc itself updates at accept time.
         ov_q   <= pend_v;
         pend_v <= 1'b0;
         if (pend_v) begin
            y_q    <= pend_y;
            flag_q <= pend_f;
         end
         if (clear) begin
            acc    <= '0;
            hi     <= '0;
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     if (op_c == OP_MUL) begin
                        state  <= ST_MUL;
                        busy_q <= 1'b1;
                        cnt    <= CW'(WIDTH);
                        mcand  <= a;
                        prod   <= {{WIDTH{1'b0}}, b};
                        sat_q  <= sat;
                     end else if (op_c != OP_NOP) begin
                        pend_v <= 1'b1;
                        pend_y <= alu_y;
                        pend_f <= alu_f;
                        if (acc_we) acc <= alu_y;
                     end
                  end
               end
               ST_MUL: begin
                  prod <= prod_nx;
                  cnt  <= cnt - 1'b1;
                  if (cnt == CW'(1)) begin
                     y_q    <= (sat_q && (prod_hi != '0)) ? '1 : prod_lo;
                     flag_q <= (prod_hi != '0);
                     hi     <= prod_hi;
                     ov_q   <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign y         = y_q;
   assign flag      = flag_q;
   assign out_valid = ov_q & ena;
   assign busy      = busy_q;

endmodule
